// File: rtl/apb_completer_mem.sv
// rtl/apb_completer_mem.sv - APB completer with register memory, fixed wait states and range error
//
// Purpose: terminates APB transfers into a DEPTH x DATA_W memory. Each access
// holds pready low for WAIT_CYCLES access-phase cycles before completing.
// Addresses at or above DEPTH complete with pslverr and never touch memory.
//
// Ports:
//   clk      system clock, rising-edge active
//   prst     asynchronous active-high reset
//   psel     completer select
//   penable  access-phase indicator
//   pwrite   1 = write, 0 = read
//   paddr    transfer address (ADDR_W)
//   pwdata   write data (DATA_W)
//   prdata   read data, valid while pready=1 on a read (DATA_W)
//   pready   transfer-complete indicator
//   pslverr  error response, valid only while pready=1

module apb_completer_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH = 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [3:0]        cnt, cnt_nxt;
  logic              pready_nxt, pslverr_nxt;
  logic [DATA_W-1:0] prdata_nxt;
  logic              latch_en, mem_we;

  // Transfer context captured at the setup edge.
  logic [IDX_W-1:0]  addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;
  logic              err_q;

  logic              err_in;
  assign err_in = ({1'b0, paddr} >= DEPTH_X);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pready_nxt  = pready;
    pslverr_nxt = pslverr;
    prdata_nxt  = prdata;
    latch_en    = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        // Only a genuine setup phase starts a transfer; psel+penable here is stray.
        if (psel && !penable) begin
          latch_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            // No wait states: the response is formed from the live bus at the setup edge.
            state_nxt   = ACCESS;
            pready_nxt  = 1'b1;
            pslverr_nxt = err_in;
            if (!pwrite) prdata_nxt = err_in ? '0 : mem[paddr[IDX_W-1:0]];
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_nxt   = IDLE;
          pready_nxt  = 1'b0;
          pslverr_nxt = 1'b0;
        end else if (penable) begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nxt   = ACCESS;
            pready_nxt  = 1'b1;
            pslverr_nxt = err_q;
            if (!write_q) prdata_nxt = err_q ? '0 : mem[addr_q];
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt   = IDLE;
          pready_nxt  = 1'b0;
          pslverr_nxt = 1'b0;
        end else if (penable) begin
          mem_we      = write_q && !err_q;
          state_nxt   = IDLE;
          pready_nxt  = 1'b0;
          pslverr_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pready  <= pready_nxt;
      pslverr <= pslverr_nxt;
      prdata  <= prdata_nxt;
    end
  end

  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (latch_en) begin
      addr_q  <= paddr[IDX_W-1:0];
      data_q  <= pwdata;
      write_q <= pwrite;
      err_q   <= err_in;
    end
  end

  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_apb_completer_mem.sv
// tb/tb_apb_completer_mem.sv - self-checking bench for apb_completer_mem (WAIT_CYCLES=2 and 0 instances)

module tb_apb_completer_mem;

  logic       clk = 1'b0;
  logic       prst = 1'b1;
  logic       psel [2];
  logic       penable [2];
  logic       pwrite [2];
  logic [7:0] paddr [2];
  logic [7:0] pwdata [2];
  logic [7:0] prdata [2];
  logic       pready [2];
  logic       pslverr [2];

  int checks = 0;
  int errors = 0;

  // Reference: plain array memory plus last read value, per instance.
  logic [7:0] ref_mem [2][16];
  logic [7:0] ref_rd [2];
  int         wait_of [2] = '{2, 0};

  typedef struct {
    int         k;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    bit         b2b;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  apb_completer_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .prst(prst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0])
  );

  apb_completer_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .prst(prst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      ref_rd[k] = 8'h00;
      for (int i = 0; i < 16; i++) ref_mem[k][i] = 8'h00;
    end
  endtask

  task automatic bus_idle();
    for (int k = 0; k < 2; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = 8'h00; pwdata[k] = 8'h00;
    end
  endtask

  // Called at a negedge. Returns after the completion edge, at the following negedge.
  task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input bit b2b, output logic [7:0] rd, output bit err);
    int         waits;
    logic [7:0] exp_rd;
    bit         exp_err;
    exp_err = (a >= 8'd16);
    exp_rd  = wr ? ref_rd[k] : (exp_err ? 8'h00 : ref_mem[k][a[3:0]]);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(negedge clk);
    // Latched values must win over whatever the bus carries during the access phase.
    penable[k] = 1'b1; paddr[k] = 8'($urandom); pwdata[k] = 8'($urandom);
    waits = 0;
    while (pready[k] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    rd  = prdata[k];
    err = pslverr[k];
    chk($sformatf("wait_states[k%0d]", k), waits, wait_of[k]);
    chk($sformatf("pslverr[k%0d a=%0h]", k, a), err, exp_err);
    chk($sformatf("prdata[k%0d a=%0h wr=%0d]", k, a, wr), rd, exp_rd);
    if (wr && !exp_err) ref_mem[k][a[3:0]] = d;
    if (!wr) ref_rd[k] = exp_rd;
    @(negedge clk);
    chk("pready_after_done", pready[k], 1'b0);
    chk("pslverr_after_done", pslverr[k], 1'b0);
    psel[k] = 1'b0; penable[k] = 1'b0;
    if (!b2b) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit         err;

    bus_idle();
    clear_model();
    prst = 1'b1;
    repeat (3) @(negedge clk);
    prst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      chk("reset_pready", pready[k], 1'b0);
      chk("reset_pslverr", pslverr[k], 1'b0);
      chk("reset_prdata", prdata[k], 8'h00);
    end

    vecs.push_back('{0, 1'b1, 8'h05, 8'h12, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h12, 1'b0});
    vecs.push_back('{1, 1'b1, 8'h0F, 8'hA5, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1, 1'b0, 8'h0F, 8'h00, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{0, 1'b1, 8'h20, 8'h77, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b1, 8'h01, 8'h11, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b1, 8'h02, 8'h22, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b1, 8'h03, 8'h33, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h03, 8'h00, 1'b1, 8'h33, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h02, 8'h00, 1'b1, 8'h22, 1'b0});
    vecs.push_back('{0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h11, 1'b0});

    foreach (vecs[i]) begin
      xfer(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].b2b, rd, err);
      chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // Reset asserted while a write sits in WAIT.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h04; pwdata[0] = 8'h55;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    chk("pready_in_wait", pready[0], 1'b0);
    #2 prst = 1'b1;
    #1 chk("pready_rst_in_wait", pready[0], 1'b0);
    bus_idle();
    @(negedge clk);
    prst = 1'b0;
    clear_model();
    @(negedge clk);
    chk("prdata_after_reset", prdata[0], 8'h00);
    xfer(0, 1'b0, 8'h04, 8'h00, 1'b0, rd, err);
    chk("read_after_reset_wait", rd, 8'h00);

    // Reset asserted while pready is high: it must drop before the next clock edge.
    xfer(0, 1'b1, 8'h08, 8'h5A, 1'b0, rd, err);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h08;
    @(negedge clk);
    penable[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("pready_before_async_rst", pready[0], 1'b1);
    chk("prdata_before_async_rst", prdata[0], 8'h5A);
    #2 prst = 1'b1;
    #1 chk("pready_async_rst", pready[0], 1'b0);
    chk("prdata_async_rst", prdata[0], 8'h00);
    bus_idle();
    @(negedge clk);
    prst = 1'b0;
    clear_model();
    @(negedge clk);
    xfer(0, 1'b0, 8'h08, 8'h00, 1'b0, rd, err);
    chk("read_after_reset_access", rd, 8'h00);

    // Abort during WAIT: prior contents must survive.
    xfer(0, 1'b1, 8'h06, 8'h3C, 1'b0, rd, err);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h06; pwdata[0] = 8'h99;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_wait_pready%0d", i), pready[0], 1'b0);
    end
    xfer(0, 1'b0, 8'h06, 8'h00, 1'b0, rd, err);
    chk("read_after_abort_wait", rd, 8'h3C);

    // Abort during ACCESS on the zero-wait instance.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h07; pwdata[1] = 8'h99;
    @(negedge clk);
    chk("pready_zero_wait", pready[1], 1'b1);
    psel[1] = 1'b0;
    @(negedge clk);
    chk("abort_access_pready", pready[1], 1'b0);
    @(negedge clk);
    xfer(1, 1'b0, 8'h07, 8'h00, 1'b0, rd, err);
    chk("read_after_abort_access", rd, 8'h00);

    // Stray psel+penable with no setup must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h09; pwdata[0] = 8'hEE;
    repeat (5) @(negedge clk);
    chk("stray_access_pready", pready[0], 1'b0);
    bus_idle();
    @(negedge clk);
    xfer(0, 1'b0, 8'h09, 8'h00, 1'b0, rd, err);
    chk("read_after_stray", rd, 8'h00);

    // Randomised traffic checked against the reference model inside xfer.
    for (int n = 0; n < 300; n++) begin
      int         k;
      bit         wr;
      bit         b2b;
      logic [7:0] a;
      logic [7:0] d;
      k   = int'($urandom_range(0, 1));
      wr  = 1'($urandom);
      b2b = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
      d   = 8'($urandom);
      xfer(k, wr, a, d, b2b, rd, err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
